// File: rtl/video_timing_sched.sv
// Raster timing generator plus SOF-locking pixel scheduler; de/hsync/vsync/pixel out 1 clk after counter position.
// Upstream stalls (ready=0) outside active pixels, while aligning to SOF, and on a misplaced SOF.
module video_timing_sched #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [23:0] pixel_data_in,
  input  logic        pixel_valid_in,
  input  logic        pixel_sof_in,
  output logic        pixel_ready_out,
  output logic [23:0] pixel_data_out,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        locked,
  output logic [15:0] underflow_cnt,
  output logic [7:0]  resync_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, SEEK, ALIGN, RUN} state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [23:0]   data_q, data_d;
  logic          de_q, hsync_q, vsync_q, locked_q;
  logic [15:0]   underflow_q;
  logic [7:0]    resync_q;

  logic h_last, v_last, active, hs_win, vs_win, at_origin, frame_end;
  logic ready, starve, resync_evt;

  assign h_last    = (h_cnt_q == H_LAST);
  assign v_last    = (v_cnt_q == V_LAST);
  assign active    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_win    = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
  assign vs_win    = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
  assign at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign frame_end = h_last && v_last;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (!enable) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    data_d     = '0;
    starve     = 1'b0;
    resync_evt = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = SEEK;
        SEEK: begin
          // Non-SOF beats are drained; the SOF beat is held for (0,0).
          ready = pixel_valid_in && !pixel_sof_in;
          if (pixel_valid_in && pixel_sof_in) state_d = ALIGN;
        end
        ALIGN: if (frame_end) state_d = RUN;
        RUN: begin
          if (active) begin
            ready = 1'b1;
            if (!pixel_valid_in) begin
              starve = 1'b1;
            end else if (pixel_sof_in && !at_origin) begin
              ready      = 1'b0;
              resync_evt = 1'b1;
              state_d    = ALIGN;
            end else begin
              data_d = pixel_data_in;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      data_q      <= '0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      locked_q    <= 1'b0;
      underflow_q <= '0;
      resync_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      data_q   <= data_d;
      de_q     <= enable && active;
      hsync_q  <= enable && hs_win;
      vsync_q  <= enable && vs_win;
      locked_q <= (state_d == RUN);
      if (starve && (underflow_q != 16'hFFFF)) underflow_q <= underflow_q + 16'd1;
      if (resync_evt && (resync_q != 8'hFF))   resync_q    <= resync_q + 8'd1;
    end
  end

  assign pixel_ready_out = ready;
  assign pixel_data_out  = data_q;
  assign de              = de_q;
  assign hsync           = hsync_q;
  assign vsync           = vsync_q;
  assign locked          = locked_q;
  assign underflow_cnt   = underflow_q;
  assign resync_cnt      = resync_q;

endmodule
